fft_spectrum_scan: RTL and testbench
====================================

Name: fft_spectrum_scan

Overview:
- Downstream consumer of the FFT result RAM. Triggers on the FFT wrapper's fft_finish flag.
- Drives the RAM read address, fetches each complex bin and computes a magnitude per bin.
- Streams (bin, magnitude) out over a ready/valid interface with a small output FIFO.
- Reports the peak bin and its magnitude at the end of each frame, for display and pitch logic.

Parameters:
- ADDR_W, 10, RAM address width (FFT size 2^ADDR_W = 1024)
- IN_W, 32, width of each signed real/imag component in the RAM word
- SCAN_BINS, 512, number of bins scanned starting at bin 0 (first half of a real-input FFT); range 2..2^ADDR_W
- SKIP_DC, 1, when 1 bin 0 is streamed but excluded from the peak search
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_fft_finish  in  1  FFT frame-complete level from the FFT wrapper; rising edge starts a scan
- o_fft_addr  out  ADDR_W  RAM read address, fed to the wrapper's fft_addr
- i_fft_data  in  2*IN_W  RAM read data: [IN_W-1:0] real, [2*IN_W-1:IN_W] imag; 1-cycle registered latency
- o_mag_valid  out  1  stream valid
- i_mag_ready  in  1  stream ready
- o_mag_data  out  MAG_W  magnitude; MAG_W = IN_W+1, or 2*IN_W+1 when MAG_SQUARED_EN is defined
- o_mag_bin  out  ADDR_W  bin index of o_mag_data
- o_mag_last  out  1  marks bin SCAN_BINS-1
- o_busy  out  1  high from scan start until o_done
- o_done  out  1  one-cycle pulse when the frame is fully drained
- o_peak_bin  out  ADDR_W  peak bin of the last completed frame
- o_peak_mag  out  MAG_W  peak magnitude of the last completed frame

Behaviour:
- Clock and reset: i_clk; reset i_rstn, asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0, finish-edge register 0.
- Start trigger: start = i_fft_finish & ~finish_d (finish_d is i_fft_finish registered). Accepted only in IDLE. Edges seen in SCAN or DRAIN are ignored; no queueing.
- IDLE: o_fft_addr = 0. On start:
  - clear the running peak (mag 0, bin 0)
  - set o_busy = 1
  - go to SCAN
- SCAN:
  - A read issues in a cycle when (fifo_count + inflight) < FIFO_DEPTH, where inflight counts read data not yet captured (0 or 1).
  - On issue, o_fft_addr holds the issued index and the issue counter increments.
  - Data for an issue in cycle t is captured in cycle t+1 (RAM latency 1). The captured bin is the index registered in cycle t.
  - After issuing bin SCAN_BINS-1, go to DRAIN.
- Magnitude stage: one registered stage after capture, then a FIFO push. Total latency from address to FIFO entry is 2 cycles.
  - Default: |re| + |im|, each abs computed at IN_W+1 bits so -2^(IN_W-1) is exact; sum at MAG_W, no overflow.
- Peak update happens in the same cycle as the FIFO push, when mag > peak_mag (strict). Ties keep the lowest bin. Bin 0 is excluded when SKIP_DC = 1.
- DRAIN: wait until inflight = 0, the magnitude stage is empty and the FIFO is empty, i.e. the last beat has been accepted. Then:
  - copy the running peak to o_peak_bin / o_peak_mag
  - pulse o_done for one cycle
  - drop o_busy
  - return to IDLE
- o_peak_* are stable between o_done pulses. They update only at o_done.
- Stream rules:
  - o_mag_valid = FIFO not empty.
  - Data is stable while valid and not ready.
  - A beat transfers on valid & ready.
  - Push and pop in the same cycle are legal when the FIFO is full.
  - The issue gating above guarantees no overflow.
- i_mag_ready held at 1 gives one bin per cycle; the scan takes SCAN_BINS + 3 cycles from start to o_done.
- Async reset mid-scan aborts immediately: FIFO flushed, o_peak_* cleared. A new rising edge on i_fft_finish is required afterwards.

Optional Feature:
- MAG_SQUARED_EN defined: magnitude is re*re + im*im.
  - MAG_W = 2*IN_W + 1.
  - The magnitude stage becomes 2 registered stages (multiply, then add); latency to FIFO push becomes 3.
  - inflight counts up to 2 and is included in the issue gating.
- Not defined: |re| + |im| with the 1-stage latency above.

Decomposition:
- Package fft_scan_pkg holds:
  - FSM state enum (IDLE, SCAN, DRAIN)
  - MAG_W derivation function
  - abs helper function
- One natural sub-module: fft_scan_fifo, a synchronous FIFO of width MAG_W+ADDR_W+1 and depth FIFO_DEPTH, with count output and async active-low reset.

Test Plan:
- Ready held high, RAM bin k = (re=k, im=-k), SCAN_BINS=512:
  - 512 beats, bin k has mag 2k, o_mag_last on bin 511
  - o_done 515 cycles after the edge; o_peak_bin=511, o_peak_mag=1022
- Ready toggled 1-of-3 cycles with random data:
  - no beat lost or duplicated, bins strictly increasing 0..511
  - valid never drops while unaccepted; data matches the model
- Tie and DC handling:
  - bin 0 = 5000 and bins 7 and 9 = 300, SKIP_DC=1 → peak_bin=7, peak_mag=300
  - same data with SKIP_DC=0 → peak_bin=0
- Edge cases:
  - re = -2^31, im = 0 → mag = 2^31 exactly, no wrap
  - i_fft_finish held high across o_done → no second scan until it falls and rises again
- Reset mid-operation:
  - deassert i_rstn at bin 200 → all outputs 0 next edge, FIFO empty
  - next finish edge → a full clean 512-bin scan
- MAG_SQUARED_EN build: re=3, im=4 → mag 25; re = im = -2^31 → mag 2^63.

Source files
------------

// File: rtl/fft_scan_pkg.sv
// -----------------------------------------------------------------------------
// fft_scan_pkg
// Shared definitions for the FFT spectrum scanner:
//   - scanner FSM state encoding
//   - magnitude width derivation (depends on MAG_SQUARED_EN)
//   - signed absolute-value helper
//
// Configuration macro: MAG_SQUARED_EN
//   undefined : magnitude = |re| + |im|,   width IN_W + 1
//   defined   : magnitude = re*re + im*im, width 2*IN_W + 1
// -----------------------------------------------------------------------------
package fft_scan_pkg;

    // state  | meaning
    // IDLE   | waiting for a rising edge on the finish flag, address held at 0
    // SCAN   | issuing RAM reads for bins 0..SCAN_BINS-1, gated by FIFO space
    // DRAIN  | all reads issued, waiting for pipeline and FIFO to empty
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // The abs helper works on a fixed 64-bit container; callers sign-extend
    // their IN_W-bit operand into it, so IN_W must not exceed 64.
    localparam int ABS_MAX_W = 64;

    function automatic int mag_width(input int in_w);
`ifdef MAG_SQUARED_EN
        return 2 * in_w + 1;
`else
        return in_w + 1;
`endif
    endfunction

    // Two's-complement negate reinterpreted as unsigned, so the most
    // negative input maps to its exact positive magnitude.
    function automatic logic [ABS_MAX_W-1:0] abs_mag(input logic signed [ABS_MAX_W-1:0] x);
        return x[ABS_MAX_W-1] ? ((~x) + ABS_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/fft_scan_fifo.sv
// -----------------------------------------------------------------------------
// fft_scan_fifo
// Small synchronous FIFO carrying {last, bin, magnitude} beats to the stream
// output. Push while full is accepted only when a pop happens in the same
// cycle. The storage is cleared on reset so the read port shows zeros.
//
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_push, i_data  write request / data
//   i_pop           read request (ignored when empty)
//   o_data          head entry
//   o_empty         no entries held
//   o_count         number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module fft_scan_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/fft_spectrum_scan.sv
// -----------------------------------------------------------------------------
// fft_spectrum_scan
// Reads the FFT result RAM after each frame, computes a magnitude per bin,
// streams (bin, magnitude) beats over ready/valid and reports the peak bin of
// the completed frame.
//
// Configuration macro: MAG_SQUARED_EN (see fft_scan_pkg). When defined the
// magnitude path gains a multiply stage, so address-to-push latency is 3
// instead of 2 and up to two reads can be in flight.
//
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_fft_finish    frame-complete level; a rising edge in IDLE starts a scan
//   o_fft_addr      RAM read address
//   i_fft_data      RAM read data {imag, real}, one cycle after the address
//   o_mag_valid     stream valid (FIFO not empty)
//   i_mag_ready     stream ready
//   o_mag_data      magnitude of the bin in o_mag_bin
//   o_mag_bin       bin index
//   o_mag_last      set on bin SCAN_BINS-1
//   o_busy          scan in progress
//   o_done          one-cycle pulse once the last beat has been accepted
//   o_peak_bin/mag  peak of the last completed frame, updated only at o_done
// -----------------------------------------------------------------------------
module fft_spectrum_scan
    import fft_scan_pkg::*;
#(
    parameter  int ADDR_W     = 10,
    parameter  int IN_W       = 32,
    parameter  int SCAN_BINS  = 512,
    parameter  int SKIP_DC    = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int MAG_W      = mag_width(IN_W)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_fft_finish,
    output logic [ADDR_W-1:0] o_fft_addr,
    input  logic [2*IN_W-1:0] i_fft_data,
    output logic              o_mag_valid,
    input  logic              i_mag_ready,
    output logic [MAG_W-1:0]  o_mag_data,
    output logic [ADDR_W-1:0] o_mag_bin,
    output logic              o_mag_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_peak_bin,
    output logic [MAG_W-1:0]  o_peak_mag
);

    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                FIFO_W   = MAG_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(SCAN_BINS - 1);

    logic [1:0]        r_state;
    logic              r_finish_d;
    logic [ADDR_W-1:0] r_issue_idx;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_bin;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_run_bin;
    logic [MAG_W-1:0]  r_run_mag;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [MAG_W-1:0]  r_peak_mag;

    logic              w_start;
    logic              w_issue;
    logic [1:0]        w_inflight;
    logic              w_push;
    logic [ADDR_W-1:0] w_push_bin;
    logic [MAG_W-1:0]  w_push_mag;
    logic              w_push_last;
    logic              w_peak_upd;
    logic              w_drained;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [FIFO_W-1:0] w_fifo_rdata;
    logic signed [IN_W-1:0] w_re;
    logic signed [IN_W-1:0] w_im;

    assign w_start = i_fft_finish & ~r_finish_d;
    assign w_re    = i_fft_data[IN_W-1:0];
    assign w_im    = i_fft_data[2*IN_W-1:IN_W];

    // Reads in flight are counted against FIFO space so every issued read
    // is guaranteed a slot when it reaches the push point.
    assign w_issue = (r_state == ST_SCAN) &&
                     ((int'(w_fifo_count) + int'(w_inflight)) < FIFO_DEPTH);

`ifdef MAG_SQUARED_EN
    localparam int PROD_W = 2 * IN_W;

    logic              r_mul_valid;
    logic [ADDR_W-1:0] r_mul_bin;
    logic [PROD_W-1:0] r_sq_re;
    logic [PROD_W-1:0] r_sq_im;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mul_valid <= 1'b0;
            r_mul_bin   <= '0;
            r_sq_re     <= '0;
            r_sq_im     <= '0;
        end else begin
            r_mul_valid <= r_rd_valid;
            r_mul_bin   <= r_rd_bin;
            r_sq_re     <= PROD_W'(w_re) * PROD_W'(w_re);
            r_sq_im     <= PROD_W'(w_im) * PROD_W'(w_im);
        end
    end

    // Squares are non-negative, so the extra top bit only has to absorb the
    // carry of the sum ((-2^(IN_W-1))^2 * 2 = 2^(2*IN_W-1)).
    assign w_push     = r_mul_valid;
    assign w_push_bin = r_mul_bin;
    assign w_push_mag = {1'b0, r_sq_re} + {1'b0, r_sq_im};
    assign w_inflight = {1'b0, r_rd_valid} + {1'b0, r_mul_valid};
`else
    assign w_push     = r_rd_valid;
    assign w_push_bin = r_rd_bin;
    assign w_push_mag = MAG_W'(abs_mag(ABS_MAX_W'(w_re))) +
                        MAG_W'(abs_mag(ABS_MAX_W'(w_im)));
    assign w_inflight = {1'b0, r_rd_valid};
`endif

    assign w_push_last = (w_push_bin == LAST_BIN);

    // Bins arrive in ascending order, so a strict compare keeps the lowest
    // bin on ties.
    assign w_peak_upd = w_push &&
                        !((SKIP_DC != 0) && (w_push_bin == '0)) &&
                        (w_push_mag > r_run_mag);

    assign w_drained = (w_inflight == 2'd0) && w_fifo_empty;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_valid <= 1'b0;
            r_rd_bin   <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_bin <= r_issue_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_finish_d  <= 1'b0;
            r_issue_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_run_bin   <= '0;
            r_run_mag   <= '0;
            r_peak_bin  <= '0;
            r_peak_mag  <= '0;
        end else begin
            r_finish_d <= i_fft_finish;
            r_done     <= 1'b0;

            if (w_peak_upd) begin
                r_run_bin <= w_push_bin;
                r_run_mag <= w_push_mag;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_SCAN;
                        r_busy      <= 1'b1;
                        r_issue_idx <= '0;
                        r_run_bin   <= '0;
                        r_run_mag   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_issue) begin
                        if (r_issue_idx == LAST_BIN) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_issue_idx <= r_issue_idx + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_peak_bin <= r_run_bin;
                        r_peak_mag <= r_run_mag;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    fft_scan_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_push),
        .i_data  ({w_push_last, w_push_bin, w_push_mag}),
        .i_pop   (o_mag_valid & i_mag_ready),
        .o_data  (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_fft_addr  = (r_state == ST_SCAN) ? r_issue_idx : '0;
    assign o_mag_valid = ~w_fifo_empty;
    assign {o_mag_last, o_mag_bin, o_mag_data} = w_fifo_rdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_peak_bin  = r_peak_bin;
    assign o_peak_mag  = r_peak_mag;

endmodule

// File: tb/tb_fft_spectrum_scan.sv
// -----------------------------------------------------------------------------
// tb_fft_spectrum_scan
// Directed bench for fft_spectrum_scan. A behavioural RAM (1-cycle read
// latency) feeds two scanners sharing all controls: u_dut (SKIP_DC=1) and
// u_dut_dc (SKIP_DC=0). Honours MAG_SQUARED_EN for its expected values.
// -----------------------------------------------------------------------------
module tb_fft_spectrum_scan;
    import fft_scan_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int IN_W      = 32;
    localparam int SCAN_BINS = 512;
    localparam int MAG_W     = mag_width(IN_W);
`ifdef MAG_SQUARED_EN
    localparam int DONE_LAT  = SCAN_BINS + 4;
`else
    localparam int DONE_LAT  = SCAN_BINS + 3;
`endif

    logic              clk;
    logic              rstn;
    logic              fft_finish;
    logic              mag_ready;

    logic [ADDR_W-1:0] addr0, addr1;
    logic [63:0]       data0, data1;
    logic              valid0, valid1;
    logic [MAG_W-1:0]  mag0, mag1;
    logic [ADDR_W-1:0] bin0, bin1;
    logic              last0, last1;
    logic              busy0, busy1;
    logic              done0, done1;
    logic [ADDR_W-1:0] pkbin0, pkbin1;
    logic [MAG_W-1:0]  pkmag0, pkmag1;

    logic [63:0]       mem [1024];
    logic [MAG_W-1:0]  got_mag [SCAN_BINS];

    int n_checks;
    int n_fail;
    int beats, bin_err, data_err, last_err, hold_err, pk_hold_err;
    int done_cyc, aborted, exp_bin, busy_seen;
    logic [ADDR_W-1:0] exp_pk_bin0, exp_pk_bin1;
    logic [MAG_W-1:0]  exp_pk_mag0, exp_pk_mag1;

    fft_spectrum_scan #(
        .ADDR_W(ADDR_W), .IN_W(IN_W), .SCAN_BINS(SCAN_BINS), .SKIP_DC(1), .FIFO_DEPTH(4)
    ) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_fft_finish(fft_finish),
        .o_fft_addr(addr0), .i_fft_data(data0),
        .o_mag_valid(valid0), .i_mag_ready(mag_ready),
        .o_mag_data(mag0), .o_mag_bin(bin0), .o_mag_last(last0),
        .o_busy(busy0), .o_done(done0),
        .o_peak_bin(pkbin0), .o_peak_mag(pkmag0)
    );

    fft_spectrum_scan #(
        .ADDR_W(ADDR_W), .IN_W(IN_W), .SCAN_BINS(SCAN_BINS), .SKIP_DC(0), .FIFO_DEPTH(4)
    ) u_dut_dc (
        .i_clk(clk), .i_rstn(rstn), .i_fft_finish(fft_finish),
        .o_fft_addr(addr1), .i_fft_data(data1),
        .o_mag_valid(valid1), .i_mag_ready(mag_ready),
        .o_mag_data(mag1), .o_mag_bin(bin1), .o_mag_last(last1),
        .o_busy(busy1), .o_done(done1),
        .o_peak_bin(pkbin1), .o_peak_mag(pkmag1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data0 <= mem[addr0];
        data1 <= mem[addr1];
    end

    function automatic logic [MAG_W-1:0] model_mag(input logic [63:0] w);
        logic signed [31:0] re;
        logic signed [31:0] im;
`ifdef MAG_SQUARED_EN
        longint pre;
        longint pim;
`else
        logic [32:0] are;
        logic [32:0] aim;
`endif
        re = w[31:0];
        im = w[63:32];
`ifdef MAG_SQUARED_EN
        pre = longint'(re) * longint'(re);
        pim = longint'(im) * longint'(im);
        return MAG_W'({1'b0, pre}) + MAG_W'({1'b0, pim});
`else
        are = re[31] ? (33'd0 - {re[31], re}) : {1'b0, re};
        aim = im[31] ? (33'd0 - {im[31], im}) : {1'b0, im};
        return MAG_W'(are) + MAG_W'(aim);
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raises i_fft_finish at the current negedge and runs one frame.
    // mode 0: ready always high; mode 1: ready high one cycle in three.
    // abort_bin >= 0 asserts reset as soon as that bin is being accepted.
    task automatic run_frame(input int mode, input int abort_bin);
        int phase;
        logic pv, pr, pl;
        logic [MAG_W-1:0]  pd;
        logic [ADDR_W-1:0] pb;
        logic [ADDR_W-1:0] pk_b;
        logic [MAG_W-1:0]  pk_m;
        beats = 0; bin_err = 0; data_err = 0; last_err = 0;
        hold_err = 0; pk_hold_err = 0; done_cyc = -1; aborted = 0; exp_bin = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pb = '0; phase = 0;
        pk_b = pkbin0;
        pk_m = pkmag0;
        fft_finish = 1'b1;
        mag_ready  = (mode == 0);
        for (int c = 0; c < 4000; c++) begin
            step();
            if (done0) begin
                done_cyc = c;
                break;
            end
            if (pv && !pr && !(valid0 && mag0 === pd && bin0 === pb && last0 === pl))
                hold_err++;
            if (pkbin0 !== pk_b || pkmag0 !== pk_m)
                pk_hold_err++;
            phase++;
            mag_ready = (mode == 0) ? 1'b1 : ((phase % 3) == 0);
            if (valid0 && mag_ready) begin
                if (int'(bin0) != exp_bin) bin_err++;
                if (exp_bin < SCAN_BINS) begin
                    if (mag0 !== model_mag(mem[exp_bin])) data_err++;
                    got_mag[exp_bin] = mag0;
                end
                if (last0 !== (exp_bin == SCAN_BINS - 1)) last_err++;
                if (int'(bin0) == abort_bin) begin
                    rstn       = 1'b0;
                    fft_finish = 1'b0;
                    aborted    = 1;
                    break;
                end
                exp_bin++;
                beats++;
            end
            pv = valid0; pr = mag_ready; pd = mag0; pb = bin0; pl = last0;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_beats"},    beats,    SCAN_BINS);
        check({tag, "_bin_err"},  bin_err,  0);
        check({tag, "_data_err"}, data_err, 0);
        check({tag, "_last_err"}, last_err, 0);
        check({tag, "_hold_err"}, hold_err, 0);
        check({tag, "_peak_hold"}, pk_hold_err, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, valid0, 0);
        check({tag, "_addr"},  addr0,  0);
        check({tag, "_data"},  mag0,   0);
        check({tag, "_bin"},   bin0,   0);
        check({tag, "_last"},  last0,  0);
        check({tag, "_busy"},  busy0,  0);
        check({tag, "_done"},  done0,  0);
        check({tag, "_pkbin"}, pkbin0, 0);
        check({tag, "_pkmag"}, pkmag0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn       = 1'b0;
        fft_finish = 1'b0;
        mag_ready  = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = {32'(-k), 32'(k)};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rstn = 1'b1;
        step(); step();
        check("idle_no_start_busy", busy0, 0);

        // Frame A: ramp (k, -k), ready high
        run_frame(0, -1);
        check_stream("ramp");
        check("ramp_done_latency", done_cyc, DONE_LAT);
        check("ramp_busy_at_done", busy0, 0);
        check("ramp_peak_bin", pkbin0, 511);
`ifdef MAG_SQUARED_EN
        check("ramp_peak_mag", pkmag0, 522242);
`else
        check("ramp_peak_mag", pkmag0, 1022);
`endif
        check("ramp_mag_bin10", got_mag[10], model_mag({32'(-10), 32'd10}));
        check("ramp_dc_peak_bin", pkbin1, 511);
        step();
        check("done_one_cycle", done0, 0);
        // finish still high: no new scan
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy0) busy_seen++;
        end
        check("held_finish_no_rescan", busy_seen, 0);
        fft_finish = 1'b0;
        step(); step();

        // Frame B: random data, ready 1-of-3
        for (int k = 0; k < 1024; k++) mem[k] = {$urandom(), $urandom()};
        exp_pk_bin0 = '0; exp_pk_mag0 = '0;
        exp_pk_bin1 = '0; exp_pk_mag1 = '0;
        for (int k = 0; k < SCAN_BINS; k++) begin
            if (k != 0 && model_mag(mem[k]) > exp_pk_mag0) begin
                exp_pk_mag0 = model_mag(mem[k]);
                exp_pk_bin0 = ADDR_W'(k);
            end
            if (model_mag(mem[k]) > exp_pk_mag1) begin
                exp_pk_mag1 = model_mag(mem[k]);
                exp_pk_bin1 = ADDR_W'(k);
            end
        end
        run_frame(1, -1);
        check_stream("rand");
        check("rand_done_seen", done_cyc > 0, 1);
        check("rand_peak_bin", pkbin0, exp_pk_bin0);
        check("rand_peak_mag", pkmag0, exp_pk_mag0);
        check("rand_dc_peak_bin", pkbin1, exp_pk_bin1);
        check("rand_dc_peak_mag", pkmag1, exp_pk_mag1);
        fft_finish = 1'b0;
        step(); step();

        // Frame C: DC and tie handling
        for (int k = 0; k < 1024; k++) mem[k] = 64'd0;
        mem[0] = {32'd0, 32'd5000};
        mem[7] = {32'd0, 32'd300};
        mem[9] = {32'(-300), 32'd0};
        run_frame(0, -1);
        check_stream("tie");
        check("tie_peak_bin", pkbin0, 7);
        check("tie_dc_peak_bin", pkbin1, 0);
`ifdef MAG_SQUARED_EN
        check("tie_peak_mag", pkmag0, 90000);
        check("tie_dc_peak_mag", pkmag1, 25000000);
`else
        check("tie_peak_mag", pkmag0, 300);
        check("tie_dc_peak_mag", pkmag1, 5000);
`endif
        fft_finish = 1'b0;
        step(); step();

        // Frame D: most-negative inputs
        for (int k = 0; k < 1024; k++) mem[k] = 64'd0;
        mem[3] = {32'd4, 32'd3};
        mem[5] = {32'd0, 32'h8000_0000};
        mem[6] = {32'h8000_0000, 32'h8000_0000};
        run_frame(0, -1);
        check_stream("edge");
        check("edge_peak_bin", pkbin0, 6);
`ifdef MAG_SQUARED_EN
        check("edge_mag_3_4", got_mag[3], 25);
        check("edge_mag_min_re", got_mag[5], 64'h4000_0000_0000_0000);
        check("edge_mag_min_both", got_mag[6], 64'h8000_0000_0000_0000);
`else
        check("edge_mag_3_4", got_mag[3], 7);
        check("edge_mag_min_re", got_mag[5], 64'h8000_0000);
        check("edge_mag_min_both", got_mag[6], 64'h1_0000_0000);
`endif
        fft_finish = 1'b0;
        step(); step();

        // Frame E: reset at bin 200
        for (int k = 0; k < 1024; k++) mem[k] = {32'(-k), 32'(k)};
        run_frame(0, 200);
        check("abort_reached", aborted, 1);
        @(posedge clk);
        #1;
        check_zero_outputs("abort");
        @(negedge clk);
        rstn = 1'b1;
        step(); step(); step();
        check("abort_no_restart", busy0, 0);

        // Frame F: clean scan after the abort
        run_frame(0, -1);
        check_stream("post_reset");
        check("post_reset_done_latency", done_cyc, DONE_LAT);
        check("post_reset_peak_bin", pkbin0, 511);
        fft_finish = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
